pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, and an optional two-entry skid buffer. It is the generic replacement for the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance carries an opaque data bundle and a control bundle. Control bits are forced to zero whenever the stage holds no valid beat, so bubbles can never write state downstream.

---
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, synchronous flush
// and an optional two-entry skid buffer. Control bits are zero whenever no beat is held.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              accept;
  logic              deliver;

  // With the skid buffer, in_ready depends only on registered state.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? (state_q != TWO) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (deliver) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        TWO: begin
          if (deliver) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Back-pressure counter saturates rather than wrapping; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench driving a skid (SKID=1) and a pass-through (SKID=0) instance with identical
// stimulus, each compared against a FIFO-of-beats reference model.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int STALL_MAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic clr_stats = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic out_ready = 1'b1;

  logic [1:0]    in_ready_w;
  logic [1:0]    out_valid_w;
  logic [DW-1:0] out_data_w [2];
  logic [CW-1:0] out_ctrl_w [2];
  logic [1:0]    occ_w [2];
  logic [NW-1:0] stall_w [2];

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, an ordered list of held {ctrl,data} beats.
  logic [CW+DW-1:0] m_ent [2][2];
  int m_size [2];
  int m_stall [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_ctrl(out_ctrl_w[0]), .occupancy(occ_w[0]), .stall_cnt(stall_w[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_pass (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_ctrl(out_ctrl_w[1]), .occupancy(occ_w[1]), .stall_cnt(stall_w[1])
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelReady(input int m);
    if (m == 0) return (m_size[0] < 2);
    return (m_size[1] == 0) || out_ready;
  endfunction

  task automatic modelClear();
    for (int m = 0; m < 2; m++) begin
      m_size[m]  = 0;
      m_stall[m] = 0;
    end
  endtask

  task automatic modelEdge();
    for (int m = 0; m < 2; m++) begin
      logic rdy, dlv, acc;
      rdy = modelReady(m);
      dlv = (m_size[m] > 0) && out_ready;
      acc = in_valid && rdy;
      if (clr_stats) m_stall[m] = 0;
      else if ((m_size[m] > 0) && !out_ready && !flush && (m_stall[m] < STALL_MAX)) m_stall[m]++;
      if (flush) begin
        m_size[m] = 0;
      end else begin
        if (dlv) begin
          m_ent[m][0] = m_ent[m][1];
          m_size[m]--;
        end
        if (acc) begin
          m_ent[m][m_size[m]] = {in_ctrl, in_data};
          m_size[m]++;
        end
      end
    end
  endtask

  task automatic checkOutput();
    for (int m = 0; m < 2; m++) begin
      logic [CW+DW-1:0] head;
      head = m_ent[m][0];
      checkVal($sformatf("inst%0d out_valid", m), 32'(out_valid_w[m]), 32'(m_size[m] > 0));
      checkVal($sformatf("inst%0d in_ready", m), 32'(in_ready_w[m]), 32'(modelReady(m)));
      checkVal($sformatf("inst%0d occupancy", m), 32'(occ_w[m]), 32'(m_size[m]));
      checkVal($sformatf("inst%0d stall_cnt", m), 32'(stall_w[m]), 32'(m_stall[m]));
      checkVal($sformatf("inst%0d out_ctrl", m), 32'(out_ctrl_w[m]),
               (m_size[m] > 0) ? 32'(head[CW+DW-1:DW]) : 32'd0);
      if (m_size[m] > 0)
        checkVal($sformatf("inst%0d out_data", m), 32'(out_data_w[m]), 32'(head[DW-1:0]));
    end
  endtask

  task automatic checkReset(input string tag);
    for (int m = 0; m < 2; m++) begin
      checkVal($sformatf("%s inst%0d out_valid", tag, m), 32'(out_valid_w[m]), 32'd0);
      checkVal($sformatf("%s inst%0d in_ready", tag, m), 32'(in_ready_w[m]), 32'd1);
      checkVal($sformatf("%s inst%0d occupancy", tag, m), 32'(occ_w[m]), 32'd0);
      checkVal($sformatf("%s inst%0d out_ctrl", tag, m), 32'(out_ctrl_w[m]), 32'd0);
      checkVal($sformatf("%s inst%0d out_data", tag, m), 32'(out_data_w[m]), 32'd0);
      checkVal($sformatf("%s inst%0d stall_cnt", tag, m), 32'(stall_w[m]), 32'd0);
    end
  endtask

  // One cycle: drive at negedge, check just after, advance the model at the posedge.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic ordy, input logic fl, input logic cl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    clr_stats = cl;
    #1;
    checkOutput();
    @(posedge clk);
    modelEdge();
  endtask

  task automatic goIdle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    clr_stats = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    modelClear();
    #2;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'(i), 8'hA5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'd10, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd11, 8'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd12, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd12, 8'h33, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'd20, 8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd21, 8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd22, 8'hFF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'd30, 8'h5A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic iv, ordy, fl, cl;
      r    = $urandom;
      iv   = (r[1:0] != 2'd0);
      ordy = (r[3:2] != 2'd0);
      fl   = (r[7:4] == 4'd0);
      cl   = (r[12:8] == 5'd0);
      r    = $urandom;
      applyStimulus(iv, r[15:0], r[23:16], ordy, fl, cl);
    end

    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0BEE, 8'hC3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0CAF, 8'h3C, 1'b0, 1'b0, 1'b0);
    #2;
    checkVal("pre-reset inst0 occupancy", 32'(occ_w[0]), 32'd2);
    goIdle();
    rst_n = 1'b0;
    #1;
    checkReset("async reset");
    modelClear();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h1234, 8'h77, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
